// File: rtl/uart_apb_ctrl.sv
// UART APB controller: APB3 register front-end with TX/RX byte FIFOs,
// a transmit sequencer driving a UART core, sticky error flags and irq.
`timescale 1ns/1ps
module uart_apb_ctrl #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [3:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        uart_enable,
  output logic        uart_start,
  output logic [7:0]  uart_data_in,
  input  logic [7:0]  uart_data_out,
  input  logic        uart_busy,
  input  logic        uart_done,
  input  logic        parity_error,
  input  logic        framing_error,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_START, S_WAIT_DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [TW-1:0]   r_tocnt;
  logic [3:0]      r_ctrl;
  logic [3:0]      r_sticky;
  logic [7:0]      r_data_in;
  logic            r_irq;
  logic [AW:0]     r_tx_wr, r_tx_rd, r_rx_wr, r_rx_rd;
  logic [7:0]      r_tx_mem [FIFO_DEPTH];
  logic [7:0]      r_rx_mem [FIFO_DEPTH];

  logic            w_access, w_wr_data, w_rd_data, w_wr_stat, w_wr_ctrl;
  logic            w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic            w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
  logic            w_timeout_hit, w_tx_active;
  logic [3:0]      w_sticky_set, w_sticky_clr;
  logic [31:0]     w_status;
  logic [1:0]      w_addr;
  logic            w_unused;

  assign w_unused   = ^{paddr[1:0], pwdata[31:9]};
  assign w_addr     = paddr[3:2];
  assign w_access   = psel & penable;
  assign w_wr_data  = w_access &  pwrite & (w_addr == 2'd0);
  assign w_rd_data  = w_access & ~pwrite & (w_addr == 2'd0);
  assign w_wr_stat  = w_access &  pwrite & (w_addr == 2'd1);
  assign w_wr_ctrl  = w_access &  pwrite & (w_addr == 2'd2);

  assign w_tx_full  = ((r_tx_wr ^ r_tx_rd) == (AW+1)'(FIFO_DEPTH));
  assign w_tx_empty = (r_tx_wr == r_tx_rd);
  assign w_rx_full  = ((r_rx_wr ^ r_rx_rd) == (AW+1)'(FIFO_DEPTH));
  assign w_rx_empty = (r_rx_wr == r_rx_rd);

  // A full TX FIFO drops the write; the sequencer pops only when it may start a frame.
  assign w_tx_push  = w_wr_data & ~w_tx_full;
  assign w_tx_pop   = (r_state == S_IDLE) & r_ctrl[0] & ~w_tx_empty & ~uart_busy;
  // A pop in the same cycle frees a slot, so a full RX FIFO can still accept the byte.
  assign w_rx_pop   = w_rd_data & ~w_rx_empty;
  assign w_rx_push  = uart_done & (~w_rx_full | w_rx_pop);

  assign w_timeout_hit = (r_state == S_WAIT_DONE) & ~uart_done &
                         (r_tocnt == TW'(TIMEOUT_CYC - 1));

  // Sticky order: {timeout, overrun, framing, parity}; set wins over clear.
  assign w_sticky_set = {w_timeout_hit, uart_done & w_rx_full & ~w_rx_pop,
                         uart_done & framing_error, uart_done & parity_error};
  assign w_sticky_clr = w_wr_stat ? {pwdata[8], pwdata[7:5]} : 4'b0;

  assign w_status = {23'b0, r_sticky, w_tx_active, w_rx_full, w_rx_empty,
                     w_tx_full, w_tx_empty};

  assign pready       = 1'b1;
  assign uart_enable  = r_ctrl[0];
  assign uart_data_in = r_data_in;
  assign irq          = r_irq;

  // Transmit sequencer state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Transmit sequencer next-state logic; a frame in flight always runs to completion.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_tx_pop) w_next = S_LOAD;
      S_LOAD:      w_next = S_START;
      S_START:     w_next = S_WAIT_DONE;
      S_WAIT_DONE: if (uart_done || w_timeout_hit) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // Transmit sequencer outputs decoded from the registered state.
  always_comb begin
    uart_start  = 1'b0;
    w_tx_active = 1'b1;
    case (r_state)
      S_IDLE:  w_tx_active = 1'b0;
      S_START: uart_start  = 1'b1;
      default: ;
    endcase
  end

  // Cycles spent waiting for the UART core, restarted on every new wait.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                       r_tocnt <= '0;
    else if (r_state != S_WAIT_DONE)   r_tocnt <= '0;
    else                               r_tocnt <= r_tocnt + 1'b1;
  end

  // Control register, sticky flags, transmit byte and interrupt.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ctrl    <= '0;
      r_sticky  <= '0;
      r_data_in <= '0;
      r_irq     <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_ctrl <= pwdata[3:0];
      r_sticky <= (r_sticky & ~w_sticky_clr) | w_sticky_set;
      if (w_tx_pop) r_data_in <= r_tx_mem[r_tx_rd[AW-1:0]];
      r_irq <= (r_ctrl[1] & ~w_rx_empty) |
               (r_ctrl[2] & w_tx_empty & ~w_tx_active) |
               (r_ctrl[3] & (|r_sticky));
    end
  end

  // FIFO pointers; reset empties both FIFOs without touching storage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tx_wr <= '0;
      r_tx_rd <= '0;
      r_rx_wr <= '0;
      r_rx_rd <= '0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
      if (w_rx_push) r_rx_wr <= r_rx_wr + 1'b1;
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + 1'b1;
    end
  end

  // FIFO storage writes.
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr[AW-1:0]] <= pwdata[7:0];
    if (w_rx_push) r_rx_mem[r_rx_wr[AW-1:0]] <= uart_data_out;
  end

  // APB read mux and error response, active only in the access phase.
  always_comb begin
    prdata  = 32'b0;
    pslverr = 1'b0;
    if (w_access) begin
      case (w_addr)
        2'd0: begin
          if (!pwrite && !w_rx_empty) prdata = {24'b0, r_rx_mem[r_rx_rd[AW-1:0]]};
          pslverr = pwrite ? w_tx_full : w_rx_empty;
        end
        2'd1: if (!pwrite) prdata = w_status;
        2'd2: if (!pwrite) prdata = {28'b0, r_ctrl};
        default: pslverr = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_apb_ctrl.sv
// Directed testbench for uart_apb_ctrl with a hand-driven UART core stub.
`timescale 1ns/1ps
module tb_uart_apb_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        psel, penable, pwrite;
  logic [3:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic        uart_enable, uart_start;
  logic [7:0]  uart_data_in;
  logic [7:0]  uart_data_out;
  logic        uart_busy, uart_done, parity_error, framing_error;
  logic        irq;

  int          assertCount = 0;
  int          failCount   = 0;
  logic [31:0] rdData;
  logic        rdErr;
  logic        wrErr;
  bit          startSeen;

  uart_apb_ctrl #(.FIFO_DEPTH(4), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .resetn(resetn),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .uart_enable(uart_enable), .uart_start(uart_start), .uart_data_in(uart_data_in),
    .uart_data_out(uart_data_out), .uart_busy(uart_busy), .uart_done(uart_done),
    .parity_error(parity_error), .framing_error(framing_error), .irq(irq)
  );

  always #5 clk = ~clk;

  // APB write: setup, access (sampled 1ns after the falling edge), idle.
  task automatic apbWrite(input logic [3:0] addr, input logic [31:0] data, output logic err);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
    @(negedge clk);
    penable = 1'b1;
    #1 err = pslverr;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  // APB read with data and error captured in the access phase.
  task automatic apbRead(input logic [3:0] addr, output logic [31:0] data, output logic err);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
    @(negedge clk);
    penable = 1'b1;
    #1 begin data = prdata; err = pslverr; end
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  // One-cycle reception pulse from the UART stub.
  task automatic pulseDone(input logic [7:0] data, input logic par, input logic frm);
    @(negedge clk);
    uart_done = 1'b1; uart_data_out = data; parity_error = par; framing_error = frm;
    @(negedge clk);
    uart_done = 1'b0; parity_error = 1'b0; framing_error = 1'b0;
  endtask

  // Wait a bounded number of cycles for a transmit request.
  task automatic waitStart(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (uart_start) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #1;
    assertCount++;
    if (uart_start !== 1'b0 || uart_enable !== 1'b0 || uart_data_in !== 8'h00 ||
        irq !== 1'b0 || pslverr !== 1'b0 || pready !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL reset_outputs: start=%b en=%b din=%h irq=%b err=%b rdy=%b, required 0/0/00/0/0/1",
               uart_start, uart_enable, uart_data_in, irq, pslverr, pready);
    end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    apbRead(4'h4, rdData, rdErr);
    assertCount++;
    if (rdData !== 32'h005 || rdErr !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_status: got %h err=%b, required 005 err=0", rdData, rdErr);
    end
    apbRead(4'h8, rdData, rdErr);
    assertCount++;
    if (rdData !== 32'h0) begin
      failCount++;
      $display("[TB] FAIL reset_ctrl: got %h, required 0", rdData);
    end
  endtask

  task automatic test_loopback();
    apbWrite(4'h8, 32'h1, wrErr);
    apbWrite(4'h0, 32'h55, wrErr);
    assertCount++;
    if (uart_enable !== 1'b1 || wrErr !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL loop_enable: en=%b err=%b, required 1 0", uart_enable, wrErr);
    end
    waitStart(20, startSeen);
    assertCount++;
    if (!startSeen || uart_data_in !== 8'h55) begin
      failCount++;
      $display("[TB] FAIL loop_start: seen=%b din=%h, required 1 55", startSeen, uart_data_in);
    end
    @(negedge clk);
    assertCount++;
    if (uart_start !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL loop_start_width: start=%b one cycle later, required 0", uart_start);
    end
    pulseDone(8'h55, 1'b0, 1'b0);
    apbRead(4'h0, rdData, rdErr);
    assertCount++;
    if (rdData !== 32'h55 || rdErr !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL loop_rxdata: got %h err=%b, required 55 err=0", rdData, rdErr);
    end
    apbRead(4'h4, rdData, rdErr);
    assertCount++;
    if (rdData !== 32'h005) begin
      failCount++;
      $display("[TB] FAIL loop_status: got %h, required 005", rdData);
    end
  endtask

  task automatic test_apb_errors();
    apbRead(4'hC, rdData, rdErr);
    assertCount++;
    if (rdData !== 32'h0 || rdErr !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL err_read_rsvd: got %h err=%b, required 0 err=1", rdData, rdErr);
    end
    apbRead(4'h0, rdData, rdErr);
    assertCount++;
    if (rdData !== 32'h0 || rdErr !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL err_read_empty: got %h err=%b, required 0 err=1", rdData, rdErr);
    end
    apbWrite(4'hC, 32'hFF, wrErr);
    assertCount++;
    if (wrErr !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL err_write_rsvd: err=%b, required 1", wrErr);
    end
    apbRead(4'h4, rdData, rdErr);
    assertCount++;
    if (rdData !== 32'h005 || rdErr !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL err_status_unchanged: got %h err=%b, required 005 err=0", rdData, rdErr);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] burst [4];
    int extraStarts;
    burst = '{8'h11, 8'h22, 8'h33, 8'h44};
    uart_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      apbWrite(4'h0, {24'h0, burst[i]}, wrErr);
      assertCount++;
      if (wrErr !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL burst_push%0d: err=%b, required 0", i, wrErr);
      end
    end
    apbWrite(4'h0, 32'h99, wrErr);
    assertCount++;
    if (wrErr !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL burst_overflow: err=%b, required 1", wrErr);
    end
    apbRead(4'h4, rdData, rdErr);
    assertCount++;
    if (rdData !== 32'h006) begin
      failCount++;
      $display("[TB] FAIL burst_status_full: got %h, required 006", rdData);
    end
    uart_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      waitStart(20, startSeen);
      assertCount++;
      if (!startSeen || uart_data_in !== burst[i]) begin
        failCount++;
        $display("[TB] FAIL burst_tx%0d: seen=%b din=%h, required 1 %h", i, startSeen, uart_data_in, burst[i]);
      end
      pulseDone(burst[i], 1'b0, 1'b0);
    end
    extraStarts = 0;
    repeat (30) begin
      @(negedge clk);
      if (uart_start) extraStarts++;
    end
    assertCount++;
    if (extraStarts !== 0) begin
      failCount++;
      $display("[TB] FAIL burst_dropped_byte: extra starts=%0d, required 0", extraStarts);
    end
    for (int i = 0; i < 4; i++) begin
      apbRead(4'h0, rdData, rdErr);
      assertCount++;
      if (rdData !== {24'h0, burst[i]} || rdErr !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL burst_rx%0d: got %h err=%b, required %h err=0", i, rdData, rdErr, burst[i]);
      end
    end
  endtask

  task automatic test_errors_overrun();
    for (int i = 0; i < 5; i++)
      pulseDone(8'hA1 + 8'(i), (i == 4), 1'b0);
    apbRead(4'h4, rdData, rdErr);
    assertCount++;
    if (rdData !== 32'h0A9) begin
      failCount++;
      $display("[TB] FAIL ovr_status: got %h, required 0a9", rdData);
    end
    for (int i = 0; i < 4; i++) begin
      apbRead(4'h0, rdData, rdErr);
      assertCount++;
      if (rdData !== 32'hA1 + i) begin
        failCount++;
        $display("[TB] FAIL ovr_rx%0d: got %h, required %h", i, rdData, 32'hA1 + i);
      end
    end
    apbWrite(4'h4, 32'h0A0, wrErr);
    apbRead(4'h4, rdData, rdErr);
    assertCount++;
    if (rdData !== 32'h005) begin
      failCount++;
      $display("[TB] FAIL ovr_w1c: got %h, required 005", rdData);
    end
    // Parity set lands in the same cycle as a W1C of the parity bit.
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'h4; pwdata = 32'h020;
    @(negedge clk);
    penable = 1'b1; uart_done = 1'b1; uart_data_out = 8'hB6; parity_error = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; uart_done = 1'b0; parity_error = 1'b0;
    apbRead(4'h4, rdData, rdErr);
    assertCount++;
    if (rdData !== 32'h021) begin
      failCount++;
      $display("[TB] FAIL sticky_set_wins: got %h, required 021", rdData);
    end
    apbRead(4'h0, rdData, rdErr);
    apbWrite(4'h4, 32'h020, wrErr);
    apbRead(4'h4, rdData, rdErr);
    assertCount++;
    if (rdData !== 32'h005) begin
      failCount++;
      $display("[TB] FAIL sticky_clear: got %h, required 005", rdData);
    end
  endtask

  task automatic test_timeout();
    int gap;
    apbWrite(4'h8, 32'h8, wrErr);
    apbWrite(4'h0, 32'h77, wrErr);
    apbWrite(4'h0, 32'h78, wrErr);
    apbWrite(4'h8, 32'h9, wrErr);
    waitStart(20, startSeen);
    assertCount++;
    if (!startSeen || uart_data_in !== 8'h77) begin
      failCount++;
      $display("[TB] FAIL to_first_start: seen=%b din=%h, required 1 77", startSeen, uart_data_in);
    end
    gap = 0;
    startSeen = 1'b0;
    while (!startSeen && gap < 300) begin
      @(negedge clk);
      gap++;
      if (uart_start) startSeen = 1'b1;
    end
    // START + 100 waiting cycles + IDLE + LOAD before the next request.
    assertCount++;
    if (gap !== 103 || uart_data_in !== 8'h78) begin
      failCount++;
      $display("[TB] FAIL to_gap: got %0d cycles din=%h, required 103 din=78", gap, uart_data_in);
    end
    assertCount++;
    if (irq !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL to_irq: irq=%b, required 1", irq);
    end
    apbRead(4'h4, rdData, rdErr);
    assertCount++;
    if (rdData !== 32'h115) begin
      failCount++;
      $display("[TB] FAIL to_status: got %h, required 115", rdData);
    end
  endtask

  task automatic test_reset_mid_frame();
    int starts;
    apbWrite(4'h0, 32'h88, wrErr);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    assertCount++;
    if (uart_start !== 1'b0 || uart_enable !== 1'b0 || uart_data_in !== 8'h00 ||
        irq !== 1'b0 || pslverr !== 1'b0 || prdata !== 32'h0) begin
      failCount++;
      $display("[TB] FAIL midrst_outputs: start=%b en=%b din=%h irq=%b err=%b prdata=%h, required all zero",
               uart_start, uart_enable, uart_data_in, irq, pslverr, prdata);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    apbWrite(4'h8, 32'h1, wrErr);
    starts = 0;
    repeat (30) begin
      @(negedge clk);
      if (uart_start) starts++;
    end
    assertCount++;
    if (starts !== 0) begin
      failCount++;
      $display("[TB] FAIL midrst_no_start: starts=%0d, required 0", starts);
    end
    apbRead(4'h4, rdData, rdErr);
    assertCount++;
    if (rdData !== 32'h005) begin
      failCount++;
      $display("[TB] FAIL midrst_status: got %h, required 005", rdData);
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 4'h0; pwdata = 32'h0;
    uart_data_out = 8'h00; uart_busy = 1'b0; uart_done = 1'b0;
    parity_error = 1'b0; framing_error = 1'b0;
    test_reset();
    test_loopback();
    test_apb_errors();
    test_back_to_back();
    test_errors_overrun();
    test_timeout();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/uart_apb_ctrl.md
UART_APB_CTRL -- requirements
Module: uart_apb_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the depth of both the TX and RX FIFOs; legal values are powers of two from 2 to 16.
REQ-002 Parameter TIMEOUT_CYC, default 2_000_000, SHALL set the maximum clk cycles allowed from uart_start to uart_done.
REQ-003 Ports SHALL be as follows, with clock and reset first:
- clk  in  1  single system clock; all logic is rising-edge.
- resetn  in  1  asynchronous active-low reset.
- psel, penable, pwrite  in  1 each  APB3 control.
- paddr  in  4  byte address; bits [1:0] are ignored.
- pwdata  in  32  APB write data.
- prdata  out  32  APB read data.
- pready  out  1  APB ready.
- pslverr  out  1  APB error.
- uart_enable  out  1  enable to the UART core.
- uart_start  out  1  one-cycle transmit request.
- uart_data_in  out  8  byte to transmit.
- uart_data_out  in  8  received byte; valid while uart_done=1.
- uart_busy  in  1  UART frame in progress.
- uart_done  in  1  one-cycle pulse on frame reception.
- parity_error, framing_error  in  1 each  error qualifiers; valid while uart_done=1.
- irq  out  1  level interrupt.

Function
REQ-004 Register map SHALL be:
- 0x0 DATA: write pushes pwdata[7:0] into the TX FIFO; read pops the RX FIFO.
- 0x4 STATUS (RO except bits [7:5]): bit0 tx_empty, bit1 tx_full, bit2 rx_empty, bit3 rx_full, bit4 tx_active, bit5 parity_err, bit6 framing_err, bit7 overrun, bit8 timeout. Bits [7:5] and bit8 are sticky and write-1-to-clear.
- 0x8 CTRL (RW, reset 0): bit0 enable, bit1 rx_irq_en, bit2 txe_irq_en, bit3 err_irq_en.
- 0xC: reserved.
REQ-005 APB SHALL be zero-wait: pready=1 constantly, and an access completes in its ACCESS phase (psel & penable); prdata SHALL be combinational during ACCESS and 0 otherwise.
REQ-006 pslverr=1 SHALL be asserted in ACCESS for:
- access to 0xC;
- write to DATA when tx_full (byte dropped);
- read of DATA when rx_empty (prdata=0, no pop).
REQ-007 Each FIFO SHALL use wrapping pointers with an extra MSB; full is (wr^rd)==FIFO_DEPTH, empty is wr==rd; a simultaneous push and pop SHALL keep the count unchanged and be legal when full or empty only where the operation is otherwise permitted.
REQ-008 uart_enable SHALL equal CTRL.enable, registered.
REQ-009 TX FSM states: IDLE, LOAD, START, WAIT_DONE.
- IDLE -> LOAD when enable & !tx_empty & !uart_busy; the FIFO head is popped into uart_data_in.
- LOAD -> START after 1 cycle.
- START asserts uart_start for exactly 1 cycle -> WAIT_DONE.
- WAIT_DONE -> IDLE on uart_done, or on the cycle counter reaching TIMEOUT_CYC, which also sets sticky timeout.
REQ-010 tx_active SHALL be 1 in every state other than IDLE; uart_data_in SHALL hold its value from LOAD until the next LOAD.
REQ-011 Clearing enable mid-transfer SHALL NOT abort the FSM; the current frame completes, and IDLE is then held while enable=0 with the TX FIFO contents kept.
REQ-012 On uart_done, uart_data_out SHALL be pushed into the RX FIFO in the same cycle, and parity_err/framing_err SHALL be set if their inputs are 1.
- If the RX FIFO is full and is not being popped in that cycle, the byte is dropped and overrun is set.
- uart_done arriving in any TX state SHALL still be captured.
REQ-013 A sticky-bit set and a W1C clear in the same cycle SHALL leave the bit set.
REQ-014 irq SHALL be registered: (rx_irq_en & !rx_empty) | (txe_irq_en & tx_empty & !tx_active) | (err_irq_en & any sticky bit).

Reset
REQ-015 resetn=0 SHALL asynchronously force:
- FSM to IDLE;
- FIFO pointers, CTRL, and sticky bits to 0;
- uart_start=0, uart_enable=0, uart_data_in=0x00, irq=0, pslverr=0.
Reset applied mid-frame SHALL discard all FIFO contents, and no uart_start SHALL follow its release until new data is written.

Verification
REQ-016 Loopback: write CTRL=0x1, write DATA=0x55 -> one uart_start pulse with uart_data_in=0x55; after uart_done, DATA read returns 0x55 and STATUS=0x005 (tx_empty, rx_empty).
REQ-017 Burst: write 0x11,0x22,0x33,0x44 with busy stub -> four uart_start pulses in order; a 5th write while full gives pslverr=1 and the byte is never transmitted.
REQ-018 Errors/overrun: inject 5 uart_done pulses with RX depth 4, the last with parity_error=1 -> STATUS bits 7 and 5 set, and RX holds the first 4 bytes; write STATUS=0x0A0 -> bits cleared.
REQ-019 Timeout: stub never asserts uart_done, TIMEOUT_CYC=100 -> FSM returns to IDLE after 100 cycles in WAIT_DONE, STATUS bit8=1, and irq=1 with err_irq_en.
REQ-020 Reset mid-frame: assert resetn=0 during WAIT_DONE -> all outputs reach their reset values immediately, and STATUS reads 0x005 after release.
REQ-021 APB errors: read 0xC or read DATA when empty -> pslverr=1, prdata=0, and no state change.
